// File: rtl/temp_sample_scheduler.sv
// Periodic TC77 sample sequencer: issues one-cycle load requests, guards each transfer with a
// timeout, averages the last four valid readings and derives hot/cold status with hysteresis.
module temp_sample_scheduler #(
    parameter int unsigned        PERIOD      = 4_800_000,
    parameter int unsigned        TIMEOUT     = 255,
    parameter logic signed [12:0] HOT_TH      = 13'sd800,
    parameter logic signed [12:0] COLD_TH     = 13'sd160,
    parameter logic [12:0]        HYST        = 13'd32,
    parameter int unsigned        FAULT_LIMIT = 3
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        ENABLE,
    output logic        nLOAD,
    input  logic        nCOMPLETE,
    input  logic [13:0] TEMPDATA,
    output logic [12:0] TEMP_AVG,
    output logic        TEMP_VALID,
    output logic        DATA_STROBE,
    output logic        TEMP_HOT,
    output logic        TEMP_COLD,
    output logic        SENSOR_FAULT
);

    localparam int unsigned PCNT_W = $clog2(PERIOD + 1);
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PCNT_W-1:0]  PERIOD_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [PCNT_W-1:0]  PCNT_MAX    = '1;
    localparam logic [TCNT_W-1:0]  TIMEOUT_LD  = TCNT_W'(TIMEOUT);
    localparam logic signed [14:0] HOT_SET     = 15'(HOT_TH);
    localparam logic signed [14:0] HOT_CLR     = 15'(HOT_TH) - $signed({2'b00, HYST});
    localparam logic signed [14:0] COLD_SET    = 15'(COLD_TH);
    localparam logic signed [14:0] COLD_CLR    = 15'(COLD_TH) + $signed({2'b00, HYST});

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StRequest,
        StWaitDone,
        StEval,
        StUpdate
    } state_e;

    state_e             r_state;
    logic [PCNT_W-1:0]  r_pcnt;
    logic [TCNT_W-1:0]  r_tcnt;
    logic [13:0]        r_sample;
    logic [1:0]         r_fail;
    logic [3:0][12:0]   r_win;
    logic signed [14:0] r_sum;
    logic [2:0]         r_fill;
    logic               r_nload;
    logic [12:0]        r_avg;
    logic               r_valid;
    logic               r_strobe;
    logic               r_hot;
    logic               r_cold;
    logic               r_fault;

    state_e             w_state_nxt;
    logic [PCNT_W-1:0]  w_pcnt_nxt;
    logic [TCNT_W-1:0]  w_tcnt_nxt;
    logic [13:0]        w_sample_nxt;
    logic [1:0]         w_fail_nxt;
    logic [3:0][12:0]   w_win_nxt;
    logic signed [14:0] w_sum_nxt;
    logic [2:0]         w_fill_nxt;
    logic               w_nload_nxt;
    logic [12:0]        w_avg_nxt;
    logic               w_valid_nxt;
    logic               w_strobe_nxt;
    logic               w_hot_nxt;
    logic               w_cold_nxt;
    logic               w_fault_nxt;
    logic               w_fail_rec;
    logic signed [14:0] w_avg15;

    always_comb begin
        w_state_nxt  = r_state;
        w_pcnt_nxt   = (r_pcnt == PCNT_MAX) ? r_pcnt : r_pcnt + 1'b1;
        w_tcnt_nxt   = r_tcnt;
        w_sample_nxt = r_sample;
        w_fail_nxt   = r_fail;
        w_win_nxt    = r_win;
        w_sum_nxt    = r_sum;
        w_fill_nxt   = r_fill;
        w_nload_nxt  = 1'b1;
        w_avg_nxt    = r_avg;
        w_valid_nxt  = r_valid;
        w_strobe_nxt = 1'b0;
        w_hot_nxt    = r_hot;
        w_cold_nxt   = r_cold;
        w_fault_nxt  = r_fault;
        w_fail_rec   = 1'b0;
        w_avg15      = '0;

        unique case (r_state)
            StIdle: begin
                w_pcnt_nxt = '0;
                if (ENABLE) begin
                    w_state_nxt = StWaitTick;
                end
            end
            StWaitTick: begin
                // A zero count only occurs straight out of IDLE: request immediately.
                if (!ENABLE) begin
                    w_state_nxt = StIdle;
                end else if ((r_pcnt == '0) || (r_pcnt >= PERIOD_LAST)) begin
                    w_state_nxt = StRequest;
                end
            end
            StRequest: begin
                w_nload_nxt = 1'b0;
                w_pcnt_nxt  = PCNT_W'(1);
                w_tcnt_nxt  = TIMEOUT_LD;
                w_state_nxt = StWaitDone;
            end
            StWaitDone: begin
                // Completion in the same cycle the timer reaches zero still counts.
                if (!nCOMPLETE) begin
                    w_sample_nxt = TEMPDATA;
                    w_state_nxt  = StEval;
                end else if (r_tcnt == '0) begin
                    w_fail_rec  = 1'b1;
                    w_state_nxt = StWaitTick;
                end else begin
                    w_tcnt_nxt = r_tcnt - 1'b1;
                end
            end
            StEval: begin
                if (!r_sample[0]) begin
                    w_fail_rec  = 1'b1;
                    w_state_nxt = StWaitTick;
                end else begin
                    w_fail_nxt  = '0;
                    w_state_nxt = StUpdate;
                end
            end
            StUpdate: begin
                // r_win[0] is the newest sample, r_win[3] the one falling out of the window.
                w_win_nxt  = {r_win[2:0], r_sample[13:1]};
                w_sum_nxt  = r_sum + 15'($signed(r_sample[13:1])) - 15'($signed(r_win[3]));
                w_fill_nxt = (r_fill == 3'd4) ? r_fill : r_fill + 1'b1;
                if (w_fill_nxt == 3'd4) begin
                    w_avg15      = w_sum_nxt >>> 2;
                    w_avg_nxt    = w_avg15[12:0];
                    w_valid_nxt  = 1'b1;
                    w_strobe_nxt = 1'b1;
                    w_hot_nxt    = r_hot ? !(w_avg15 < HOT_CLR) : (w_avg15 >= HOT_SET);
                    w_cold_nxt   = r_cold ? !(w_avg15 > COLD_CLR) : (w_avg15 <= COLD_SET);
                end
                w_state_nxt = ENABLE ? StWaitTick : StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Reaching the fault limit flushes the window; TEMP_AVG holds until it refills.
        if (w_fail_rec) begin
            w_fail_nxt = (r_fail == 2'd3) ? r_fail : r_fail + 1'b1;
            if (32'(w_fail_nxt) >= FAULT_LIMIT) begin
                w_fault_nxt = 1'b1;
                w_win_nxt   = '0;
                w_sum_nxt   = '0;
                w_fill_nxt  = '0;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state  <= StIdle;
            r_pcnt   <= '0;
            r_tcnt   <= '0;
            r_sample <= '0;
            r_fail   <= '0;
            r_win    <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
            r_nload  <= 1'b1;
            r_avg    <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_hot    <= 1'b0;
            r_cold   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_sample <= w_sample_nxt;
            r_fail   <= w_fail_nxt;
            r_win    <= w_win_nxt;
            r_sum    <= w_sum_nxt;
            r_fill   <= w_fill_nxt;
            r_nload  <= w_nload_nxt;
            r_avg    <= w_avg_nxt;
            r_valid  <= w_valid_nxt;
            r_strobe <= w_strobe_nxt;
            r_hot    <= w_hot_nxt;
            r_cold   <= w_cold_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    assign nLOAD        = r_nload;
    assign TEMP_AVG     = r_avg;
    assign TEMP_VALID   = r_valid;
    assign DATA_STROBE  = r_strobe;
    assign TEMP_HOT     = r_hot;
    assign TEMP_COLD    = r_cold;
    assign SENSOR_FAULT = r_fault;

endmodule
